serial_sub_n: RTL and testbench



---
 rtl/serial_sub_n.sv | 132 +++++++++++++
 tb/tb_serial_sub_n.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_n.sv
// Multi-cycle N-bit subtractor: a - b - bin, STEP bits per clock, LSB slice first.
// Valid/ready handshake on both sides; result registers load only when the last slice completes.
module serial_sub_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("serial_sub_n: STEP must be >= 1 and divide WIDTH");
  end

  localparam int NCYC = WIDTH / STEP;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | one STEP-bit slice subtracted per clock
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q, b_q, work_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, ovf_q, zero_q;

  logic [STEP-1:0]  slice_a, slice_b;
  logic [STEP:0]    diff;
  logic [WIDTH-1:0] work_d;
  logic             borrow_d;
  logic             ovf_d;
  int               idx;

  // The top bit of the STEP+1-bit difference is set exactly when the slice went negative.
  always_comb begin
    idx      = int'(cnt_q) * STEP;
    slice_a  = a_q[idx +: STEP];
    slice_b  = b_q[idx +: STEP];
    diff     = {1'b0, slice_a} - {1'b0, slice_b} - {{STEP{1'b0}}, borrow_q};
    work_d   = work_q;
    work_d[idx +: STEP] = diff[STEP-1:0];
    borrow_d = diff[STEP];
    ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= bin;
            cnt_q      <= '0;
            work_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          work_q   <= work_d;
          borrow_q <= borrow_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            d_q         <= work_d;
            bout_q      <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= (work_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// Bench for serial_sub_n: four instances (1/1, 8/1, 16/4, 16/16) checked against
// an arithmetic reference model with directed and random operands.
module tb_serial_sub_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv, ordy;
  logic [15:0] a_s, b_s;
  logic        bin_s;

  logic        ir1, ov1, bo1, of1, z1;
  logic [0:0]  d1;
  logic        ir8, ov8, bo8, of8, z8;
  logic [7:0]  d8;
  logic        ir4, ov4, bo4, of4, z4;
  logic [15:0] d4;
  logic        ir16, ov16, bo16, of16, z16;
  logic [15:0] d16;

  int          sel_m;
  logic        m_ir, m_ov, m_bo, m_of, m_z;
  logic [15:0] m_d;

  int checks = 0;
  int errors = 0;
  int W_T[4] = '{1, 8, 16, 16};
  int S_T[4] = '{1, 1, 4, 16};

  always #5 clk = ~clk;

  serial_sub_n #(.WIDTH(1), .STEP(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir1), .a(a_s[0:0]), .b(b_s[0:0]),
    .bin(bin_s), .out_valid(ov1), .out_ready(ordy[0]), .d(d1), .bout(bo1), .ovf(of1), .zero(z1));
  serial_sub_n #(.WIDTH(8), .STEP(1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .a(a_s[7:0]), .b(b_s[7:0]),
    .bin(bin_s), .out_valid(ov8), .out_ready(ordy[1]), .d(d8), .bout(bo8), .ovf(of8), .zero(z8));
  serial_sub_n #(.WIDTH(16), .STEP(4)) u_w16s4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir4), .a(a_s), .b(b_s),
    .bin(bin_s), .out_valid(ov4), .out_ready(ordy[2]), .d(d4), .bout(bo4), .ovf(of4), .zero(z4));
  serial_sub_n #(.WIDTH(16), .STEP(16)) u_w16s16 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir16), .a(a_s), .b(b_s),
    .bin(bin_s), .out_valid(ov16), .out_ready(ordy[3]), .d(d16), .bout(bo16), .ovf(of16), .zero(z16));

  always_comb begin
    m_ir = ir8; m_ov = ov8; m_d = {8'h00, d8}; m_bo = bo8; m_of = of8; m_z = z8;
    case (sel_m)
      0: begin m_ir = ir1;  m_ov = ov1;  m_d = {15'h0, d1}; m_bo = bo1;  m_of = of1;  m_z = z1;  end
      2: begin m_ir = ir4;  m_ov = ov4;  m_d = d4;          m_bo = bo4;  m_of = of4;  m_z = z4;  end
      3: begin m_ir = ir16; m_ov = ov16; m_d = d16;         m_bo = bo16; m_of = of16; m_z = z16; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bn,
                       output logic [15:0] ed, output logic eb, output logic eo, output logic ez);
    longint mod, ua, ub, sa, sb, r, half;
    mod  = longint'(1) << w;
    half = mod / 2;
    ua   = longint'(a) % mod;
    ub   = longint'(b) % mod;
    r    = ua - ub - longint'(bn);
    ed   = 16'(((r % mod) + mod) % mod);
    eb   = (ua < ub + longint'(bn));
    sa   = (ua >= half) ? ua - mod : ua;
    sb   = (ub >= half) ? ub - mod : ub;
    r    = sa - sb - longint'(bn);
    eo   = (r < -half) || (r > half - 1);
    ez   = (ed == 16'h0);
  endtask

  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic bn, input int hold);
    logic [15:0] ed;
    logic        eb, eo, ez;
    int          cyc;
    string       t;
    t = $sformatf("i%0d a=%0h b=%0h bin=%0b", sel, a, b, bn);
    model(W_T[sel], a, b, bn, ed, eb, eo, ez);
    sel_m = sel;
    #1;
    chk({t, " in_ready"}, 32'(m_ir), 32'd1);
    a_s = a; b_s = b; bin_s = bn; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    a_s = 16'($urandom); b_s = 16'($urandom); bin_s = 1'($urandom);
    cyc = 0;
    while (!m_ov && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({t, " latency"}, 32'(cyc), 32'(W_T[sel] / S_T[sel]));
    chk({t, " d"}, 32'(m_d), 32'(ed));
    chk({t, " bout"}, 32'(m_bo), 32'(eb));
    chk({t, " ovf"}, 32'(m_of), 32'(eo));
    chk({t, " zero"}, 32'(m_z), 32'(ez));
    for (int h = 0; h < hold; h++) begin
      a_s = 16'($urandom); b_s = 16'($urandom); iv[sel] = 1'b1;
      @(posedge clk); #1;
      chk({t, " hold out_valid"}, 32'(m_ov), 32'd1);
      chk({t, " hold in_ready"}, 32'(m_ir), 32'd0);
      chk({t, " hold flags"}, {13'h0, m_bo, m_of, m_z, m_d}, {13'h0, eb, eo, ez, ed});
    end
    iv = '0;
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy = '0;
    chk({t, " release out_valid"}, 32'(m_ov), 32'd0);
    chk({t, " release in_ready"}, 32'(m_ir), 32'd1);
    chk({t, " result held"}, 32'(m_d), 32'(ed));
  endtask

  initial begin
    int seen;
    rst = 1'b1; iv = '0; ordy = '0; a_s = '0; b_s = '0; bin_s = 1'b0; sel_m = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", {28'h0, ir1, ir8, ir4, ir16}, 32'hF);
    chk("reset out_valid", {28'h0, ov1, ov8, ov4, ov16}, 32'h0);
    chk("reset d8/flags", {21'h0, bo8, of8, z8, d8}, 32'h0);
    chk("reset d16", 32'(d16), 32'h0);

    for (int k = 0; k < 8; k++)
      do_op(0, 16'((k >> 2) & 1), 16'((k >> 1) & 1), 1'(k & 1), 0);

    do_op(1, 16'h00, 16'h01, 1'b0, 0);
    do_op(1, 16'h80, 16'h01, 1'b0, 0);
    do_op(1, 16'h05, 16'h04, 1'b1, 0);
    do_op(2, 16'h1234, 16'h0235, 1'b1, 0);
    do_op(3, 16'h1234, 16'h0235, 1'b1, 0);
    do_op(1, 16'h00, 16'h00, 1'b1, 0);
    do_op(2, 16'h8000, 16'h0001, 1'b0, 0);
    do_op(3, 16'h7FFF, 16'hFFFF, 1'b0, 0);
    do_op(1, 16'h3C, 16'hA5, 1'b1, 5);

    for (int r = 0; r < 20; r++)
      for (int s = 0; s < 4; s++)
        do_op(s, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Abort an 8-cycle operation on its 3rd RUN cycle.
    do_op(1, 16'h80, 16'h01, 1'b0, 0);
    sel_m = 1;
    a_s = 16'h33; b_s = 16'h11; bin_s = 1'b0; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort in_ready", 32'(ir8), 32'd1);
    chk("abort outputs", {20'h0, ov8, bo8, of8, z8, d8}, 32'h0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    chk("abort no out_valid", 32'(seen), 32'd0);
    do_op(1, 16'h10, 16'h01, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
